// File: rtl/tl_arb_mux_pkg.sv
// Shared helpers for the TileLink-style arbitrating merge.
package tl_arb_mux_pkg;

  // Width of a source index for n ports (never below 1 bit).
  function automatic int unsigned sel_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin successor of idx among n ports.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tl_arb_mux_if.sv
// Valid/ready bundle between N sources, the merge and its single sink.
interface tl_arb_mux_if
  import tl_arb_mux_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = sel_w(N)
);
  logic [N-1:0]        valid_i;
  logic [N-1:0]        ready_o;
  logic [N*DATA_W-1:0] data_i;
  logic [N-1:0]        last_i;
  logic                valid_o;
  logic                ready_i;
  logic [DATA_W-1:0]   data_o;
  logic                last_o;
  logic [SEL_W-1:0]    src_o;

  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, last_o, src_o
  );

  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, src_o
  );
endinterface

// File: rtl/tl_arb_mux_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module tl_arb_mux_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);
  int unsigned idx;

  always_comb begin
    grant_idx_o = ptr_i;
    grant_vld_o = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!grant_vld_o && req_i[idx]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = SEL_W'(idx);
      end
    end
  end
endmodule

// File: rtl/tl_arb_mux.sv
// N-to-1 round-robin merge with burst locking.
// Define TL_ARB_MUX_OUT_REG_EN to register the output through a 2-entry skid buffer.
module tl_arb_mux
  import tl_arb_mux_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = sel_w(N)
) (
  input logic         clk,
  input logic         rst,
  tl_arb_mux_if.slave bus
);
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              locked_q, locked_d;
  logic [SEL_W-1:0]  lock_idx_q, lock_idx_d;
  logic [SEL_W-1:0]  arb_idx, grant;
  logic              arb_vld, valid_a, last_a, acc_rdy;
  logic [DATA_W-1:0] data_a;
  logic [N-1:0]      ready_vec;

  tl_arb_mux_rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_i       (bus.valid_i),
    .ptr_i       (rr_ptr_q),
    .grant_idx_o (arb_idx),
    .grant_vld_o (arb_vld)
  );

  always_comb begin
    grant   = locked_q ? lock_idx_q : arb_idx;
    valid_a = locked_q ? bus.valid_i[grant] : arb_vld;
    data_a  = bus.data_i[32'(grant)*DATA_W +: DATA_W];
    last_a  = bus.last_i[grant];
  end

  // Hold the grant through stalls and non-final beats; release on the last accepted beat.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (valid_a) begin
      if (acc_rdy && last_a) begin
        locked_d = 1'b0;
        rr_ptr_d = SEL_W'(wrap_inc(32'(grant), N));
      end else begin
        locked_d   = 1'b1;
        lock_idx_d = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    ready_vec = '0;
    if (!rst) ready_vec[grant] = acc_rdy;
  end
  assign bus.ready_o = ready_vec;

`ifdef TL_ARB_MUX_OUT_REG_EN
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [SEL_W-1:0]  src;
  } beat_t;

  beat_t      mem_q [2];
  beat_t      mem_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic       wr_q, wr_d, rd_q, rd_d;
  logic       push, pop;

  always_comb begin
    acc_rdy = (cnt_q != 2'd2);
    push    = valid_a && acc_rdy;
    pop     = (cnt_q != 2'd0) && bus.ready_i;
    mem_d   = mem_q;
    if (push) mem_d[wr_q] = '{data: data_a, last: last_a, src: grant};
    wr_d    = wr_q ^ push;
    rd_d    = rd_q ^ pop;
    cnt_d   = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  assign bus.valid_o = (cnt_q != 2'd0);
  assign bus.data_o  = mem_q[rd_q].data;
  assign bus.last_o  = mem_q[rd_q].last;
  assign bus.src_o   = mem_q[rd_q].src;
`else
  assign acc_rdy     = bus.ready_i;
  assign bus.valid_o = !rst && valid_a;
  assign bus.data_o  = rst ? '0 : data_a;
  assign bus.last_o  = !rst && last_a;
  assign bus.src_o   = rst ? '0 : grant;
`endif
endmodule

// File: tb/tb_tl_arb_mux.sv
// Directed checks of tl_arb_mux in its default combinational-output build.
module tb_tl_arb_mux;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tl_arb_mux_if #(.N(4), .DATA_W(8), .SEL_W(2)) bus ();

  tl_arb_mux #(.N(4), .DATA_W(8), .SEL_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                            input logic l, input logic [1:0] s, input logic [3:0] r);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
    check({tag, ".data"},  32'(bus.data_o),  32'(d));
    check({tag, ".last"},  32'(bus.last_o),  32'(l));
    check({tag, ".src"},   32'(bus.src_o),   32'(s));
    check({tag, ".ready"}, 32'(bus.ready_o), 32'(r));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: everything forced low even with requests pending
    rst         = 1'b1;
    bus.valid_i = 4'b1111;
    bus.last_i  = 4'b1111;
    bus.data_i  = 32'h33221100;
    bus.ready_i = 1'b1;
    #1;
    expect_out("rst", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
    tick();
    rst = 1'b0;

    // Port 0 alone
    bus.valid_i = 4'b0001;
    bus.data_i  = 32'h000000A0;
    #1;
    expect_out("t1", 1'b1, 8'hA0, 1'b1, 2'd0, 4'b0001);
    tick();
    bus.valid_i = 4'b0000;
    #1;
    check("t1_idle.valid", 32'(bus.valid_o), 32'd0);
    check("t1_idle.src",   32'(bus.src_o),   32'd1);

    // Port 3 alone brings rr_ptr back to 0
    bus.valid_i = 4'b1000;
    bus.data_i  = 32'hB3B2B1B0;
    #1;
    check("t2_prep.src", 32'(bus.src_o), 32'd3);
    tick();

    // All ports single-beat: 0,1,2,3 then wrap to 0
    bus.valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t2_rr%0d.src", k), 32'(bus.src_o), 32'(k % 4));
      check($sformatf("t2_rr%0d.data", k), 32'(bus.data_o), 32'(8'hB0 + k % 4));
      tick();
    end
    bus.valid_i = 4'b0000;

    // Port 1 alone moves rr_ptr to 2
    bus.valid_i = 4'b0010;
    bus.data_i  = 32'h00C0D100;
    #1;
    check("t3_prep.src", 32'(bus.src_o), 32'd1);
    tick();

    // Port 2 three-beat burst not interleaved by port 1
    bus.valid_i = 4'b0110;
    for (int b = 0; b < 3; b++) begin
      bus.data_i[23:16] = 8'hC0 + 8'(b);
      bus.last_i[2]     = (b == 2);
      #1;
      check($sformatf("t3_b%0d.src", b),  32'(bus.src_o),  32'd2);
      check($sformatf("t3_b%0d.data", b), 32'(bus.data_o), 32'(8'hC0 + b));
      check($sformatf("t3_b%0d.last", b), 32'(bus.last_o), 32'(b == 2));
      tick();
    end
    #1;
    expect_out("t3_after", 1'b1, 8'hD1, 1'b1, 2'd1, 4'b0010);
    tick();
    bus.valid_i = 4'b0000;

    // Port 3 stalled two cycles while port 0 joins; 3 must win first
    bus.valid_i = 4'b1000;
    bus.data_i  = 32'hE30000F0;
    bus.ready_i = 1'b0;
    #1;
    expect_out("t4_stall0", 1'b1, 8'hE3, 1'b1, 2'd3, 4'b0000);
    tick();
    bus.valid_i = 4'b1001;
    #1;
    expect_out("t4_stall1", 1'b1, 8'hE3, 1'b1, 2'd3, 4'b0000);
    tick();
    bus.ready_i = 1'b1;
    #1;
    expect_out("t4_accept", 1'b1, 8'hE3, 1'b1, 2'd3, 4'b1000);
    tick();
    #1;
    expect_out("t4_next", 1'b1, 8'hF0, 1'b1, 2'd0, 4'b0001);
    tick();

    // Port 1 burst interrupted by reset; re-arbitration restarts at port 0
    bus.valid_i = 4'b0011;
    bus.data_i  = 32'h000060F0;
    bus.last_i  = 4'b1101;
    #1;
    expect_out("t5_beat1", 1'b1, 8'h60, 1'b0, 2'd1, 4'b0010);
    tick();
    rst = 1'b1;
    #1;
    expect_out("t5_rst", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
    tick();
    rst = 1'b0;
    #1;
    expect_out("t5_after", 1'b1, 8'hF0, 1'b1, 2'd0, 4'b0001);
    tick();
    bus.valid_i = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
